// File: rtl/btn_condition.sv
// btn_condition -- push-button conditioner for the mode FSM.
//
// Each of the three raw buttons is brought into the clk domain through its
// own 2-flop synchronizer and then debounced by a per-button counter: a
// synchronized value that disagrees with the accepted level for DB_CYCLES
// consecutive cycles is accepted.  A raw change held steady therefore shows
// up on btn_level on the (DB_CYCLES+2)th rising edge after it is first
// sampled.
//
// Configuration macro: BTN_PULSE_EN
//   undefined : btn is a level command, equal to btn_level when exactly one
//               button is down, 3'b000 otherwise.
//   defined   : btn[i] pulses for one cycle on the first cycle btn_level[i]
//               is 1, unless that press coincides with a chord.
//
// Parameters
//   DB_CYCLES  stable-sample count to accept a change (legal 2..2^CNT_W-1)
//   CNT_W      width of each per-button debounce counter
// Ports
//   clk        single clock, all flops on its rising edge
//   rst        asynchronous active-low reset
//   btn_raw    [2:0] bouncing push-button inputs, active-high
//   btn        [2:0] conditioned one-hot command (registered)
//   btn_level  [2:0] debounced level of each button (registered)
//   chord      high while two or more debounced buttons are down (registered)
module btn_condition #(
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned CNT_W     = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    output logic [2:0] btn,
    output logic [2:0] btn_level,
    output logic       chord
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [CNT_W-1:0] cnt      [3];
    logic [CNT_W-1:0] cnt_next [3];
    logic [2:0]       level_next;
    logic [2:0]       btn_next;
    logic             chord_next;

    // Two-flop synchronizer per button; nothing else looks at btn_raw.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: the counter only runs while the synchronized
    // value disagrees with the accepted level, and it saturates at the
    // accept point by toggling the level and clearing instead of wrapping.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            level_next[i] = btn_level[i];
            cnt_next[i]   = '0;
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_next[i] = ~btn_level[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // All outputs are derived from the next level so that btn, btn_level
    // and chord update together on the same edge.
    always_comb begin
        chord_next = (level_next[0] & level_next[1]) |
                     (level_next[0] & level_next[2]) |
                     (level_next[1] & level_next[2]);
`ifdef BTN_PULSE_EN
        // Rising edge of the accepted level; two simultaneous rises always
        // imply a chord, so the result is at most one-hot.
        btn_next = (level_next & ~btn_level) & {3{~chord_next}};
`else
        // Not a chord and non-zero means exactly one bit is set.
        btn_next = chord_next ? 3'b000 : level_next;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
            btn_level <= '0;
            btn       <= '0;
            chord     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= cnt_next[i];
            end
            btn_level <= level_next;
            btn       <= btn_next;
            chord     <= chord_next;
        end
    end

endmodule
